// File: rtl/internal_paths_pkg.sv
// Shared types and constants for the internal-paths capture block.
// Holds the capture FSM encoding, default sizes and the window-counter width helper.
package internal_paths_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_DEF   = 8;

  // Window counter must be able to hold the value WIN itself.
  function automatic int win_cnt_w(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/sat_edge_counter.sv
// Saturating event counter: synchronous clear has priority over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/internal_paths_capture.sv
// Captures a WIN-cycle window of the shared internal_paths `out` net, counts its
// edges and compares the window against a pattern latched at arm time.
module internal_paths_capture
  import internal_paths_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN   = WIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out_i,
  input  logic [WIN-1:0]   expect_pat,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [WIN-1:0]   capture,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
);

  localparam int             WCW  = win_cnt_w(WIN);
  localparam logic [WCW-1:0] LAST = WCW'(WIN - 1);

  state_e         state_q;
  logic           s1_q, s0_q;
  logic [WIN-1:0] cap_q;
  logic [WIN-1:0] pat_q;
  logic [WCW-1:0] win_q;
  logic           match_q, busy_q, done_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge value of the others (s0_q takes the old s1_q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      cap_q   <= '0;
      pat_q   <= '0;
      win_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1_q   <= out_i;
      s0_q   <= s1_q;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end
        ST_ARM: begin
          cap_q   <= '0;
          match_q <= 1'b0;
          win_q   <= '0;
          pat_q   <= expect_pat;
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          cap_q <= {cap_q[WIN-2:0], s1_q};
          win_q <= win_q + WCW'(1);
          // Outputs are registered so busy/done line up with the state they describe.
          if (win_q == LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          match_q <= (cap_q == pat_q);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic counting;
  assign counting = (state_q == ST_CAPTURE);

  sat_edge_counter #(.CNT_W(CNT_W)) u_rise_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_ARM),
    .inc (counting && s1_q && !s0_q),
    .cnt (rise_cnt)
  );

  sat_edge_counter #(.CNT_W(CNT_W)) u_fall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_ARM),
    .inc (counting && !s1_q && s0_q),
    .cnt (fall_cnt)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign match   = match_q;
  assign capture = cap_q;

endmodule

// File: doc/internal_paths_capture.md
INTERNAL_PATHS_CAPTURE -- requirements
Module: internal_paths_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of each edge counter, legal range 2..32.
REQ-002 Parameter WIN, default 8: capture window length in cycles, legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request one capture window; honoured only in IDLE.
REQ-006 out_i  input  1  observed net, driven by the shared `out` of the internal_paths_top instances; synchronous to clk.
REQ-007 expect_pat  input  WIN  expected window contents, latched in ARM.
REQ-008 busy  output  1  high in ARM and CAPTURE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 match  output  1  compare result; valid from DONE until the next ARM.
REQ-011 capture  output  WIN  captured window; oldest sample in MSB.
REQ-012 rise_cnt  output  CNT_W  rising edges seen in the window.
REQ-013 fall_cnt  output  CNT_W  falling edges seen in the window.

Function
REQ-014 out_i shall be registered every cycle into s1, and s1 into s0; s1 is the "sample" and s0 the "previous sample".
REQ-015 FSM states: IDLE, ARM, CAPTURE, DONE.
REQ-016 IDLE -> ARM when start=1; otherwise stay in IDLE.
REQ-017 ARM lasts exactly 1 cycle and shall:
- clear capture, rise_cnt, fall_cnt, match and the window counter;
- latch expect_pat;
- then go to CAPTURE.
REQ-018 CAPTURE lasts exactly WIN cycles; each cycle capture <= {capture[WIN-2:0], s1}.
REQ-019 In CAPTURE, rise_cnt increments when s1=1 and s0=0, and fall_cnt increments when s1=0 and s0=1.
REQ-020 Both counters shall saturate at 2^CNT_W-1 and never wrap.
REQ-021 After the WIN-th CAPTURE cycle the FSM goes to DONE.
REQ-022 In DONE, for exactly 1 cycle:
- done=1;
- match <= (capture == latched pattern);
- then go to IDLE.
REQ-023 Latency: start sampled at edge N gives ARM in cycle N+1, CAPTURE in cycles N+2..N+WIN+1, DONE in cycle N+WIN+2.
REQ-024 start shall be ignored in ARM, CAPTURE and DONE; it is not queued.
REQ-025 capture, counters and match shall hold their values in IDLE until the next ARM.
REQ-026 Changes on expect_pat after ARM shall not affect match.

Reset
REQ-027 While rst=1, the block shall asynchronously hold:
- FSM in IDLE;
- s0, s1, capture, rise_cnt, fall_cnt, match, busy, done and the window counter at 0.
REQ-028 Reset during ARM or CAPTURE shall abort the window with no done pulse.
REQ-029 The first start after rst deasserts shall be honoured normally.

Structure
REQ-030 Package internal_paths_pkg shall hold:
- the FSM state enum;
- CNT_W and WIN default constants;
- the window-counter width function clog2(WIN+1).
REQ-031 One sub-module, sat_edge_counter (parameter CNT_W; inputs clr, inc; output cnt), shall be instantiated twice, once for rises and once for falls.
REQ-032 Target size is 120-400 lines of RTL.

Verification
REQ-033 Reset check: assert rst mid-window -> all outputs 0 immediately, done never pulses, FSM in IDLE.
REQ-034 Pattern match, WIN=8: prior s1=0, samples 1,0,1,1,0,0,1,0 in CAPTURE, expect_pat=8'b10110010 ->
- done at start+10;
- capture=8'b10110010, match=1;
- rise_cnt=3, fall_cnt=3.
REQ-035 Mismatch: same stimulus with expect_pat=8'b10110011 -> match=0; capture and counters unchanged from REQ-034.
REQ-036 Saturation: CNT_W=2, WIN=8, prior s1=0, s1 toggling every cycle -> rise_cnt=3, fall_cnt=3, no wrap.
REQ-037 Ignored start: pulse start during CAPTURE and during DONE -> exactly one done pulse; FSM returns to IDLE and stays there.
REQ-038 Back-to-back: start held high continuously -> done pulses every WIN+3 cycles; counters cleared at each ARM.
